vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 21 ++
 rtl/vga_rx.sv | 175 +++++++++++++++++
 tb/tb_vga_rx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared VGA timing constants and receiver types.
// Defaults describe 1024x768 @ 60 Hz on a 65 MHz pixel clock.
package vga_rx_pkg;

    localparam int unsigned H_TOTAL_DEF      = 1344;
    localparam int unsigned H_ACTIVE_DEF     = 1024;
    localparam int unsigned H_SYNC_START_DEF = 1048;
    localparam int unsigned H_SYNC_END_DEF   = 1184;
    localparam int unsigned V_TOTAL_DEF      = 806;
    localparam int unsigned V_ACTIVE_DEF     = 768;
    localparam int unsigned V_SYNC_START_DEF = 771;
    localparam int unsigned V_SYNC_END_DEF   = 777;

    localparam int CW = 11;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } rx_state_t;

    function automatic logic [CW-1:0] wrap_inc(
        input logic [CW-1:0] c,
        input logic [CW-1:0] last
    );
        return (c == last) ? '0 : c + CW'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// One-cycle registered copy of a sync line with
// combinational rise/fall pulses against that copy.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/vga_rx.sv
// VGA timing receiver: recovers pixel position from syncs,
// tracks lock, flags timing errors and checksums frames.
module vga_rx
    import vga_rx_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        de_out,
    output logic [11:0] rgb_out,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_count
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_SYNC_START);
    localparam logic [CW-1:0] H_SE   = CW'(H_SYNC_END);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS   = CW'(V_SYNC_START);
    localparam logic [CW-1:0] V_SE   = CW'(V_SYNC_END);

    rx_state_t     state, state_nx;
    logic          err_seen, err_seen_nx;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] cur_h, cur_v;
    logic [CW-1:0] h_nx, v_nx;
    logic          hs_rise, hs_fall, vs_rise, vs_fall;
    logic          active, h_bad, v_bad, any_err;
    logic          vis, latch_sum;
    logic [15:0]   acc;

    sync_edge_det u_hs (
        .clk   (pclk),
        .rst_n (rst),
        .d     (hsync_in),
        .rise  (hs_rise),
        .fall  (hs_fall)
    );

    sync_edge_det u_vs (
        .clk   (pclk),
        .rst_n (rst),
        .d     (vsync_in),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    assign active = (state != SEARCH);

    assign h_bad = active &&
        ((hs_rise && h_cnt != H_SS) ||
         (hs_fall && h_cnt != H_SE));

    assign v_bad = active &&
        ((vs_rise && (h_cnt != '0 || v_cnt != V_SS)) ||
         (vs_fall && (h_cnt != '0 || v_cnt != V_SE)));

    assign any_err = h_bad | v_bad;

    // Position of the sample on the inputs right now,
    // snapped to the sync edge when the prediction was wrong.
    always_comb begin
        cur_h = h_cnt;
        cur_v = v_cnt;
        if (vs_rise && (!active || v_bad)) begin
            cur_h = '0;
            cur_v = V_SS;
        end else if (vs_fall && v_bad) begin
            cur_h = '0;
            cur_v = V_SE;
        end else if (hs_rise && h_bad) begin
            cur_h = H_SS;
        end else if (hs_fall && h_bad) begin
            cur_h = H_SE;
        end
    end

    assign h_nx = wrap_inc(cur_h, H_LAST);
    assign v_nx = (cur_h == H_LAST) ? wrap_inc(cur_v, V_LAST)
                                    : cur_v;

    assign vis = active && (cur_h < H_ACT) && (cur_v < V_ACT);

    // An error counts against the ACQUIRE pass it lands in,
    // so re-lock needs one clean vsync-to-vsync frame.
    always_comb begin
        state_nx    = state;
        err_seen_nx = err_seen;
        unique case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nx    = ACQUIRE;
                    err_seen_nx = 1'b0;
                end
            end
            ACQUIRE: begin
                if (any_err) begin
                    err_seen_nx = 1'b1;
                end else if (vs_rise) begin
                    if (err_seen) err_seen_nx = 1'b0;
                    else          state_nx    = LOCKED;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_nx    = ACQUIRE;
                    err_seen_nx = 1'b1;
                end
            end
            default: begin
                state_nx    = SEARCH;
                err_seen_nx = 1'b0;
            end
        endcase
    end

    assign latch_sum = (state == LOCKED) && vs_rise && !any_err;
    assign locked    = (state == LOCKED);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            err_seen   <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            acc        <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            de_out     <= 1'b0;
            rgb_out    <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            err_seen   <= err_seen_nx;
            h_cnt      <= h_nx;
            v_cnt      <= v_nx;
            hcount_out <= cur_h;
            vcount_out <= cur_v;
            de_out     <= vis;
            rgb_out    <= rgb_in;
            frame_done <= latch_sum;
            h_err      <= h_bad;
            v_err      <= v_bad;
            if (latch_sum) frame_sum <= acc;
            if (vs_rise)  acc <= '0;
            else if (vis) acc <= acc + {4'b0000, rgb_in};
            if (any_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a reduced 20x10 raster
// (12x6 visible) so that whole frames run quickly.
module tb_vga_rx;

    localparam int HT  = 20;
    localparam int HA  = 12;
    localparam int HSS = 14;
    localparam int HSE = 17;
    localparam int VT  = 10;
    localparam int VA  = 6;
    localparam int VSS = 7;
    localparam int VSE = 8;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        de_out;
    logic [11:0] rgb_out;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic        h_err;
    logic        v_err;
    logic [7:0]  err_count;

    vga_rx #(
        .H_TOTAL      (HT),
        .H_ACTIVE     (HA),
        .H_SYNC_START (HSS),
        .H_SYNC_END   (HSE),
        .V_TOTAL      (VT),
        .V_ACTIVE     (VA),
        .V_SYNC_START (VSS),
        .V_SYNC_END   (VSE)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rgb_in     (rgb_in),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .de_out     (de_out),
        .rgb_out    (rgb_out),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .h_err      (h_err),
        .v_err      (v_err),
        .err_count  (err_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int h;
        int v;
        int de;
        int rgb;
        bit chk;
    } px_t;

    px_t         px_q[$];
    logic [15:0] sum_q[$];

    int checks = 0;
    int passes = 0;

    int gh = 0, gv = 0;
    int mode = 1, mode_req = 1;
    int stall_lines = 0;
    bit stall_rand = 0;
    int rep = 0;
    bit is_rep = 0;
    int quiet = 0;
    int vs_edges = 0;
    bit vs_prev = 0;
    int herr_n = 0, verr_n = 0;

    task automatic check(input string name, input int act,
                         input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d",
                      name, act, exp);
    endtask

    // Hand-computed sums over 72 visible pixels:
    // dot FFF -> 0FFF, 72*0x123 -> 51D8, 72*0xFFF mod 2^16 -> 7FB8
    function automatic logic [15:0] exp_sum(input int m);
        case (m)
            0:       return 16'h0FFF;
            1:       return 16'h51D8;
            default: return 16'h7FB8;
        endcase
    endfunction

    function automatic int pix(input int m, input int h, input int v);
        case (m)
            0:       return (h == 0 && v == 0) ? 12'hFFF : 0;
            1:       return 12'h123;
            default: return 12'hFFF;
        endcase
    endfunction

    // Stimulus: raster generator; a stall repeats h=HSS-1,
    // delaying the hsync edge and shifting all later timing.
    initial begin : gen
        px_t e;
        bit  hs, vs;
        forever begin
            @(posedge pclk);
            #1;
            if (gh == 0 && gv == 0) mode = mode_req;
            hs = (gh >= HSS && gh < HSE);
            vs = (gv >= VSS && gv < VSE);
            hsync_in = hs;
            vsync_in = vs;
            rgb_in   = 12'(pix(mode, gh, gv));
            e.h   = gh;
            e.v   = gv;
            e.de  = (gh < HA && gv < VA) ? 1 : 0;
            e.rgb = pix(mode, gh, gv);
            e.chk = !is_rep;
            px_q.push_back(e);
            if (!rst) quiet = 0;
            if (vs && !vs_prev) begin
                vs_edges++;
                if (rst) quiet++;
                if (quiet >= 3) sum_q.push_back(exp_sum(mode));
            end
            vs_prev = vs;
            if (rep == 0 && !is_rep && gh == HSS - 1 &&
                stall_lines > 0) begin
                rep = stall_rand ? $urandom_range(3, 1) : 1;
                stall_lines--;
                quiet = 0;
            end
            if (rep > 0) begin
                rep--;
                is_rep = 1;
            end else begin
                is_rep = 0;
                if (gh == HT - 1) begin
                    gh = 0;
                    gv = (gv == VT - 1) ? 0 : gv + 1;
                end else begin
                    gh++;
                end
            end
        end
    end

    initial begin : px_mon
        px_t e;
        forever begin
            @(posedge pclk);
            if (px_q.size() == 0) continue;
            e = px_q.pop_front();
            @(negedge pclk);
            if (rst && locked && e.chk) begin
                check("hcount", int'(hcount_out), e.h);
                check("vcount", int'(vcount_out), e.v);
                check("de", int'(de_out), e.de);
                check("rgb", int'(rgb_out), e.rgb);
            end
        end
    end

    initial begin : evt_mon
        logic [15:0] exp;
        forever begin
            @(negedge pclk);
            if (h_err) herr_n++;
            if (v_err) verr_n++;
            if (frame_done) begin
                check("fd_expected", int'(sum_q.size() > 0), 1);
                if (sum_q.size() > 0) begin
                    exp = sum_q.pop_front();
                    check("frame_sum", int'(frame_sum), int'(exp));
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        check({tag, "_hcount"}, int'(hcount_out), 0);
        check({tag, "_vcount"}, int'(vcount_out), 0);
        check({tag, "_de"}, int'(de_out), 0);
        check({tag, "_rgb"}, int'(rgb_out), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_fdone"}, int'(frame_done), 0);
        check({tag, "_fsum"}, int'(frame_sum), 0);
        check({tag, "_herr"}, int'(h_err), 0);
        check({tag, "_verr"}, int'(v_err), 0);
        check({tag, "_errcnt"}, int'(err_count), 0);
    endtask

    task automatic wait_edges(input int n);
        int target;
        int budget;
        target = vs_edges + n;
        budget = n * HT * VT * 3;
        while (vs_edges < target && budget > 0) begin
            @(negedge pclk);
            budget--;
        end
        check("vsync_wait", int'(vs_edges >= target), 1);
    endtask

    initial begin : test
        int base;
        int budget;

        repeat (30) @(negedge pclk);
        chk_zero("rst0");
        rst = 1'b1;

        wait_edges(1);
        @(negedge pclk);
        check("lock_e1", int'(locked), 0);
        wait_edges(1);
        @(negedge pclk);
        check("lock_e2", int'(locked), 1);
        mode_req = 0;
        wait_edges(1);
        mode_req = 2;
        wait_edges(1);
        mode_req = 1;
        wait_edges(1);
        @(negedge pclk);
        check("clean_errcnt", int'(err_count), 0);
        check("clean_herr", herr_n, 0);
        check("clean_verr", verr_n, 0);

        base = herr_n;
        stall_rand = 0;
        stall_lines = 1;
        budget = 200;
        while (!h_err && budget > 0) begin
            @(negedge pclk);
            budget--;
        end
        check("herr_seen", int'(h_err), 1);
        check("lock_drop", int'(locked), 0);
        @(negedge pclk);
        check("herr_pulse", int'(h_err), 0);
        check("errcnt_1", int'(err_count), 1);
        check("herr_once", herr_n - base, 1);
        check("verr_none", verr_n, 0);
        wait_edges(1);
        @(negedge pclk);
        check("relock_e1", int'(locked), 0);
        wait_edges(1);
        @(negedge pclk);
        check("relock_e2", int'(locked), 1);
        wait_edges(1);

        budget = HT * VT * 2;
        while (!(gv == 3 && gh == 5) && budget > 0) begin
            @(negedge pclk);
            budget--;
        end
        check("mid_frame", gv, 3);
        rst = 1'b0;
        repeat (3) @(negedge pclk);
        chk_zero("rst_mid");
        rst = 1'b1;
        wait_edges(1);
        @(negedge pclk);
        check("rlk_e1", int'(locked), 0);
        wait_edges(1);
        @(negedge pclk);
        check("rlk_e2", int'(locked), 1);
        wait_edges(1);

        base = herr_n;
        stall_rand = 1;
        stall_lines = 300;
        budget = 20000;
        while (stall_lines > 0 && budget > 0) begin
            @(negedge pclk);
            budget--;
        end
        repeat (30) @(negedge pclk);
        check("stalls_done", stall_lines, 0);
        check("errcnt_sat", int'(err_count), 255);
        check("herr_300", herr_n - base, 300);
        check("verr_still0", verr_n, 0);
        wait_edges(2);
        @(negedge pclk);
        check("final_lock", int'(locked), 1);
        wait_edges(1);
        repeat (3) @(negedge pclk);
        check("fd_all_seen", sum_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
